// File: rtl/swo_uart_rx_if.sv
// Received-byte handshake between the SWO receiver and the trace capture path.
// The receiver drives the byte and its valid flag; the consumer drives ready.
interface swo_uart_rx_if;
   logic [7:0] O_data;
   logic       O_data_valid;
   logic       I_ready;

   modport master (output O_data, output O_data_valid, input I_ready);
   modport slave  (input O_data, input O_data_valid, output I_ready);
endinterface

// File: rtl/swo_uart_rx.sv
// SWO NRZ/UART trace receiver: synchronises the pin, deserialises frames and
// hands bytes to a single-entry valid/ready hold buffer with sticky status.
module swo_uart_rx #(
   parameter int unsigned pDIV_WIDTH   = 8,
   parameter int unsigned pSYNC_STAGES = 2
) (
   input  logic                  trace_clk,
   input  logic                  reset_n,
   input  logic                  I_swo,
   input  logic                  I_swo_enable,
   input  logic [pDIV_WIDTH-1:0] I_swo_bitrate_div,
   input  logic [1:0]            I_uart_stop_bits,
   input  logic [3:0]            I_uart_data_bits,
   input  logic                  I_clear_errors,
   swo_uart_rx_if.master         byte_if,
   output logic                  O_framing_error,
   output logic                  O_overflow,
   output logic                  O_busy
);

   localparam int unsigned PW       = pDIV_WIDTH + 1;
   localparam int unsigned DIV_MIN  = 3;
   localparam int unsigned DATA_MIN = 5;
   localparam int unsigned DATA_MAX = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAITHI
   } state_t;

   state_t                  state_q, state_d;
   logic [pSYNC_STAGES-1:0] sync_q;
   logic                    s_prev_q;
   logic [pDIV_WIDTH-1:0]   cnt_q, cnt_d;
   logic [pDIV_WIDTH-1:0]   div_q, div_d;
   logic [3:0]              nbits_q, nbits_d;
   logic                    two_stop_q, two_stop_d;
   logic [2:0]              bit_q, bit_d;
   logic                    stop_idx_q, stop_idx_d;
   logic [7:0]              shreg_q, shreg_d;
   logic [7:0]              data_q, data_d;
   logic                    valid_q, valid_d;
   logic                    fe_q, fe_d;
   logic                    ovf_q, ovf_d;
   logic                    busy_q, busy_d;

   logic                    s_c;
   logic                    fall_c;
   logic                    sample_c;
   logic [pDIV_WIDTH-1:0]   cnt_next_c;
   logic [pDIV_WIDTH-1:0]   div_clamp_c;
   logic [PW-1:0]           period_c;
   logic [pDIV_WIDTH-1:0]   half_load_c;
   logic [3:0]              nbits_clamp_c;
   logic                    two_stop_c;
   logic                    deliver_c;
   logic                    fe_set_c;
   logic                    load_c;

   // Pin synchroniser output and its falling-edge detect
   assign s_c    = sync_q[pSYNC_STAGES-1];
   assign fall_c = s_prev_q & ~s_c;

   // Bit-period timer: sample on zero, then reload for a full period
   assign sample_c   = (cnt_q == '0);
   assign cnt_next_c = sample_c ? div_q : cnt_q - pDIV_WIDTH'(1);

   // Clamped configuration, captured only when a frame starts
   assign div_clamp_c   = (I_swo_bitrate_div < pDIV_WIDTH'(DIV_MIN)) ? pDIV_WIDTH'(DIV_MIN)
                                                                     : I_swo_bitrate_div;
   assign period_c      = {1'b0, div_clamp_c} + PW'(1);
   assign half_load_c   = pDIV_WIDTH'((period_c >> 1) - PW'(1));
   assign nbits_clamp_c = (I_uart_data_bits < 4'(DATA_MIN)) ? 4'(DATA_MIN) :
                          (I_uart_data_bits > 4'(DATA_MAX)) ? 4'(DATA_MAX) : I_uart_data_bits;
   assign two_stop_c    = (I_uart_stop_bits >= 2'd2);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      nbits_d    = nbits_q;
      two_stop_d = two_stop_q;
      bit_d      = bit_q;
      stop_idx_d = stop_idx_q;
      shreg_d    = shreg_q;
      deliver_c  = 1'b0;
      fe_set_c   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (I_swo_enable && fall_c) begin
               state_d    = S_START;
               cnt_d      = half_load_c;
               div_d      = div_clamp_c;
               nbits_d    = nbits_clamp_c;
               two_stop_d = two_stop_c;
               bit_d      = 3'd0;
               stop_idx_d = 1'b0;
               shreg_d    = 8'd0;
            end
         end
         S_START: begin
            cnt_d = cnt_next_c;
            if (sample_c) state_d = s_c ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            cnt_d = cnt_next_c;
            if (sample_c) begin
               shreg_d[bit_q] = s_c;
               bit_d          = bit_q + 3'd1;
               if (bit_q == 3'(nbits_q - 4'd1)) state_d = S_STOP;
            end
         end
         S_STOP: begin
            cnt_d = cnt_next_c;
            if (sample_c) begin
               if (!s_c) begin
                  fe_set_c = 1'b1;
                  state_d  = S_WAITHI;
               end else if (stop_idx_q == two_stop_q) begin
                  deliver_c = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         // A held-low line (break) must return high before a new start is accepted
         S_WAITHI: begin
            if (s_c) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (!I_swo_enable) begin
         state_d   = S_IDLE;
         deliver_c = 1'b0;
         fe_set_c  = 1'b0;
      end

      // Hold buffer: a completed byte loads if the slot is free or drains this cycle
      load_c  = deliver_c && (!valid_q || byte_if.I_ready);
      valid_d = load_c || (valid_q && !byte_if.I_ready);
      data_d  = load_c ? shreg_q : data_q;
      fe_d    = fe_set_c || (fe_q && !I_clear_errors);
      ovf_d   = (deliver_c && valid_q && !byte_if.I_ready) || (ovf_q && !I_clear_errors);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge trace_clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         sync_q     <= '1;
         s_prev_q   <= 1'b1;
         cnt_q      <= '0;
         div_q      <= '0;
         nbits_q    <= 4'd0;
         two_stop_q <= 1'b0;
         bit_q      <= 3'd0;
         stop_idx_q <= 1'b0;
         shreg_q    <= 8'd0;
         data_q     <= 8'd0;
         valid_q    <= 1'b0;
         fe_q       <= 1'b0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= {sync_q[pSYNC_STAGES-2:0], I_swo};
         s_prev_q   <= s_c;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         nbits_q    <= nbits_d;
         two_stop_q <= two_stop_d;
         bit_q      <= bit_d;
         stop_idx_q <= stop_idx_d;
         shreg_q    <= shreg_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         fe_q       <= fe_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
      end
   end

   assign byte_if.O_data       = data_q;
   assign byte_if.O_data_valid = valid_q;
   assign O_framing_error      = fe_q;
   assign O_overflow           = ovf_q;
   assign O_busy               = busy_q;

endmodule

// File: tb/tb_swo_uart_rx.sv
// Self-checking bench for swo_uart_rx: directed scenarios plus random frames
// checked against a frame-level model (clamps, masking and delivery cycle).
module tb_swo_uart_rx;

   localparam int unsigned DIV_W = 8;
   localparam int          SYNC  = 2;

   logic             trace_clk = 1'b0;
   logic             reset_n;
   logic             swo;
   logic             en;
   logic [DIV_W-1:0] div;
   logic [1:0]       sbits;
   logic [3:0]       dbits;
   logic             clr;
   logic             fe;
   logic             ovf;
   logic             busy;

   swo_uart_rx_if byte_if ();

   swo_uart_rx #(.pDIV_WIDTH(DIV_W), .pSYNC_STAGES(SYNC)) dut (
      .trace_clk         (trace_clk),
      .reset_n           (reset_n),
      .I_swo             (swo),
      .I_swo_enable      (en),
      .I_swo_bitrate_div (div),
      .I_uart_stop_bits  (sbits),
      .I_uart_data_bits  (dbits),
      .I_clear_errors    (clr),
      .byte_if           (byte_if),
      .O_framing_error   (fe),
      .O_overflow        (ovf),
      .O_busy            (busy)
   );

   always #5 trace_clk = ~trace_clk;

   int cyc = 0;
   always @(posedge trace_clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_data_q[$];
   int exp_cyc_q[$];
   int mon_d;
   int mon_c;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge trace_clk);
         #1;
      end
   endtask

   // Reference rules for the effective frame format
   function automatic int eff_p(input int raw);
      return ((raw < 3) ? 3 : raw) + 1;
   endfunction

   function automatic int eff_d(input int raw);
      return (raw < 5) ? 5 : ((raw > 8) ? 8 : raw);
   endfunction

   function automatic int eff_s(input int raw);
      return (raw == 0) ? 1 : ((raw == 3) ? 2 : raw);
   endfunction

   task automatic cfg(input int d_raw, input int db_raw, input int sb_raw);
      div   = DIV_W'(d_raw);
      dbits = 4'(db_raw);
      sbits = 2'(sb_raw);
   endtask

   // Drive one frame; when expected, queue the byte and the cycle it must appear
   task automatic send(input logic [7:0] b, input int d, input int s, input int p,
                       input bit bad, input bit expect_it);
      int k;
      k = cyc;
      if (expect_it && !bad) begin
         exp_data_q.push_back(int'(b) & ((1 << d) - 1));
         exp_cyc_q.push_back(k + SYNC + 1 + p / 2 + (d + s) * p);
      end
      swo = 1'b0;
      step(p);
      for (int i = 0; i < d; i++) begin
         swo = b[i];
         step(p);
      end
      for (int i = 0; i < s; i++) begin
         swo = (bad && (i == s - 1)) ? 1'b0 : 1'b1;
         step(p);
      end
      swo = 1'b1;
   endtask

   task automatic pulse_clear();
      clr = 1'b1;
      step(1);
      clr = 1'b0;
   endtask

   // Every accepted byte must match the next queued expectation
   always @(negedge trace_clk) begin
      if (reset_n && byte_if.O_data_valid && byte_if.I_ready) begin
         chk("byte_expected", 32'(exp_data_q.size() > 0), 32'd1);
         if (exp_data_q.size() > 0) begin
            mon_d = exp_data_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            chk("rx_data", 32'(byte_if.O_data), mon_d);
            if (mon_c >= 0) chk("rx_cycle", cyc, mon_c);
         end
      end
   end

   initial begin
      int k;
      reset_n = 1'b0;
      swo     = 1'b1;
      en      = 1'b1;
      clr     = 1'b0;
      byte_if.I_ready = 1'b1;
      cfg(7, 8, 1);
      step(3);
      chk("rst_valid", 32'(byte_if.O_data_valid), 0);
      chk("rst_data", 32'(byte_if.O_data), 0);
      chk("rst_fe", 32'(fe), 0);
      chk("rst_ovf", 32'(ovf), 0);
      chk("rst_busy", 32'(busy), 0);
      reset_n = 1'b1;
      step(3);
      chk("idle_busy", 32'(busy), 0);

      // Basic 8N1 byte
      cfg(7, 8, 1);
      send(8'hA5, 8, 1, 8, 1'b0, 1'b1);
      step(4);
      chk("t1_fe", 32'(fe), 0);
      chk("t1_ovf", 32'(ovf), 0);
      chk("t1_pending", exp_data_q.size(), 0);

      // 5 data bits, 2 stop bits; then a low second stop bit
      cfg(7, 5, 2);
      send(8'h1B, 5, 2, 8, 1'b0, 1'b1);
      step(4);
      chk("t2_pending", exp_data_q.size(), 0);
      chk("t2_fe_good", 32'(fe), 0);
      send(8'h1B, 5, 2, 8, 1'b1, 1'b1);
      step(2);
      chk("t2_fe_bad", 32'(fe), 1);
      chk("t2_valid_bad", 32'(byte_if.O_data_valid), 0);
      pulse_clear();
      chk("t2_fe_clr", 32'(fe), 0);

      // Short low glitch is rejected at the start-bit sample
      cfg(15, 8, 1);
      k = cyc;
      swo = 1'b0;
      step(3);
      swo = 1'b1;
      step(2);
      chk("t3_busy_hi", 32'(busy), 1);
      step(7);
      chk("t3_busy_lo", 32'(busy), 0);
      chk("t3_fe", 32'(fe), 0);
      chk("t3_ovf", 32'(ovf), 0);
      chk("t3_valid", 32'(byte_if.O_data_valid), 0);

      // Overflow while the consumer stalls
      cfg(7, 8, 1);
      byte_if.I_ready = 1'b0;
      send(8'h11, 8, 1, 8, 1'b0, 1'b0);
      step(2);
      send(8'h22, 8, 1, 8, 1'b0, 1'b0);
      step(4);
      chk("t4_data", 32'(byte_if.O_data), 32'h11);
      chk("t4_valid", 32'(byte_if.O_data_valid), 1);
      chk("t4_ovf", 32'(ovf), 1);
      pulse_clear();
      chk("t4_ovf_clr", 32'(ovf), 0);
      chk("t4_valid_kept", 32'(byte_if.O_data_valid), 1);
      exp_data_q.push_back(32'h11);
      exp_cyc_q.push_back(-1);
      byte_if.I_ready = 1'b1;
      step(2);
      chk("t4_drained", exp_data_q.size(), 0);
      chk("t4_valid_lo", 32'(byte_if.O_data_valid), 0);

      // Enable dropped mid-frame discards the partial byte
      swo = 1'b0;
      step(8);
      swo = 1'b1;
      step(16);
      chk("t5_busy_hi", 32'(busy), 1);
      en = 1'b0;
      step(1);
      chk("t5_busy_lo", 32'(busy), 0);
      step(60);
      chk("t5_valid", 32'(byte_if.O_data_valid), 0);
      en = 1'b1;
      step(2);
      send(8'h3C, 8, 1, 8, 1'b0, 1'b1);
      step(4);
      chk("t5_pending", exp_data_q.size(), 0);

      // Divider change mid-frame only affects the next frame
      cfg(7, 8, 1);
      fork
         send(8'h96, 8, 1, 8, 1'b0, 1'b1);
         begin
            step(20);
            div = DIV_W'(15);
         end
      join
      step(4);
      chk("t6_pending_a", exp_data_q.size(), 0);
      send(8'h69, 8, 1, 16, 1'b0, 1'b1);
      step(4);
      chk("t6_pending_b", exp_data_q.size(), 0);

      // Reset mid-frame with a byte held in the buffer
      byte_if.I_ready = 1'b0;
      send(8'hC3, 8, 1, 16, 1'b0, 1'b0);
      step(4);
      chk("t6_held", 32'(byte_if.O_data), 32'hC3);
      fork
         send(8'h5A, 8, 1, 16, 1'b0, 1'b0);
         begin
            step(40);
            chk("t6_busy_pre", 32'(busy), 1);
            reset_n = 1'b0;
            step(1);
            chk("t6_rst_valid", 32'(byte_if.O_data_valid), 0);
            chk("t6_rst_data", 32'(byte_if.O_data), 0);
            chk("t6_rst_fe", 32'(fe), 0);
            chk("t6_rst_ovf", 32'(ovf), 0);
            chk("t6_rst_busy", 32'(busy), 0);
         end
      join
      step(2);
      reset_n = 1'b1;
      byte_if.I_ready = 1'b1;
      step(4);

      // Random frames, raw config fields exercise the clamps
      for (int n = 0; n < 40; n++) begin
         int d_raw, db_raw, sb_raw, p, d, s;
         logic [7:0] b;
         bit bad;
         d_raw  = int'($urandom_range(0, 20));
         db_raw = int'($urandom_range(0, 15));
         sb_raw = int'($urandom_range(0, 3));
         b      = 8'($urandom);
         bad    = ($urandom_range(0, 4) == 0);
         p      = eff_p(d_raw);
         d      = eff_d(db_raw);
         s      = eff_s(sb_raw);
         cfg(d_raw, db_raw, sb_raw);
         send(b, d, s, p, bad, 1'b1);
         if (bad) begin
            step(2);
            chk("rnd_fe_set", 32'(fe), 1);
            pulse_clear();
            chk("rnd_fe_clr", 32'(fe), 0);
         end else begin
            step(int'($urandom_range(0, 3)));
         end
      end
      step(40);
      chk("rnd_pending", exp_data_q.size(), 0);
      chk("rnd_ovf", 32'(ovf), 0);
      chk("rnd_fe", 32'(fe), 0);
      chk("rnd_busy", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
